// File: rtl/pix_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pix_fifo
// Brief    : Tagged FWFT FIFO between the slave arbiter and the image master,
//            with back-pressure flags and per-frame drain completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module pix_fifo #(
   parameter int DW       = 32,
   parameter int DEPTH    = 16,
   parameter int AW       = $clog2(DEPTH),
   parameter int AFULL_TH = DEPTH - 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_wr_valid,
   input  logic [DW-1:0] i_wr_data,
   input  logic [1:0]    i_wr_mode,
   input  logic [7:0]    i_wr_proc_val,
   input  logic          i_wr_src,
   output logic          o_fifo_full,
   output logic          o_fifo_afull,
   input  logic          i_rd_ready,
   output logic          o_rd_valid,
   output logic [DW-1:0] o_rd_data,
   output logic [1:0]    o_rd_mode,
   output logic [7:0]    o_rd_proc_val,
   output logic          o_rd_src,
   input  logic [15:0]   i_frame_len,
   output logic          o_frame_cmplt,
   input  logic          i_flush,
   output logic [AW:0]   o_count,
   output logic          o_ovf_err
);

   localparam int          c_EW    = DW + 11;
   localparam logic [AW:0] c_ONE   = (AW+1)'(1);
   localparam logic [AW:0] c_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0] c_AFULL = (AW+1)'(AFULL_TH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   logic [c_EW-1:0] r_mem [DEPTH];
   logic [AW:0]     r_wr_ptr;
   logic [AW:0]     r_rd_ptr;
   logic [AW:0]     r_count;
   logic            r_full;
   logic            r_afull;
   logic            r_ovf;
   state_t          r_state;
   logic [15:0]     r_fcnt;

   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_start;
   logic [AW:0]     w_count_nxt;
   logic [c_EW-1:0] w_head;
   state_t          w_state_nxt;
   logic [15:0]     w_fcnt_nxt;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_push  = i_wr_valid && !r_full && !i_flush;
   assign w_pop   = !w_empty && i_rd_ready && !i_flush;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + c_ONE;
         2'b01:   w_count_nxt = r_count - c_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_afull  <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_afull  <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ONE;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == c_FULL);
         r_afull <= (w_count_nxt >= c_AFULL);
         if (i_wr_valid && r_full) r_ovf <= 1'b1;
      end
   end

   // Storage is deliberately not reset; the read side masks it while empty.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {i_wr_src, i_wr_proc_val, i_wr_mode, i_wr_data};
   end

   assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
   assign o_rd_valid    = !w_empty;
   assign o_rd_data     = w_empty ? '0 : w_head[DW-1:0];
   assign o_rd_mode     = w_empty ? '0 : w_head[DW+1:DW];
   assign o_rd_proc_val = w_empty ? '0 : w_head[DW+9:DW+2];
   assign o_rd_src      = w_empty ? 1'b0 : w_head[DW+10];
   assign o_fifo_full   = r_full;
   assign o_fifo_afull  = r_afull;
   assign o_count       = r_count;
   assign o_ovf_err     = r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_fcnt  <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
      end
   end

   // A pop outside ACTIVE opens a new frame as its first beat.
   assign w_start = w_pop && (i_frame_len != 16'd0);

   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      if (i_flush) begin
         w_state_nxt = S_IDLE;
         w_fcnt_nxt  = 16'd0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start) begin
                  if (i_frame_len == 16'd1) begin
                     w_state_nxt = S_DONE;
                     w_fcnt_nxt  = 16'd0;
                  end else begin
                     w_state_nxt = S_ACTIVE;
                     w_fcnt_nxt  = 16'd1;
                  end
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_ACTIVE: begin
               if (w_pop) begin
                  if ((r_fcnt + 16'd1) == i_frame_len) begin
                     w_state_nxt = S_DONE;
                     w_fcnt_nxt  = 16'd0;
                  end else begin
                     w_fcnt_nxt  = r_fcnt + 16'd1;
                  end
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_fcnt_nxt  = 16'd0;
            end
         endcase
      end
   end

   assign o_frame_cmplt = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pix_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_pix_fifo
// Brief    : Directed scoreboard bench for pix_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pix_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_valid;
   logic [DW-1:0] wr_data;
   logic [1:0]    wr_mode;
   logic [7:0]    wr_proc_val;
   logic          wr_src;
   logic          fifo_full;
   logic          fifo_afull;
   logic          rd_ready;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic [1:0]    rd_mode;
   logic [7:0]    rd_proc_val;
   logic          rd_src;
   logic [15:0]   frame_len;
   logic          frame_cmplt;
   logic          flush;
   logic [AW:0]   count;
   logic          ovf_err;

   pix_fifo #(.DW(DW), .DEPTH(DEPTH)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_wr_valid    (wr_valid),
      .i_wr_data     (wr_data),
      .i_wr_mode     (wr_mode),
      .i_wr_proc_val (wr_proc_val),
      .i_wr_src      (wr_src),
      .o_fifo_full   (fifo_full),
      .o_fifo_afull  (fifo_afull),
      .i_rd_ready    (rd_ready),
      .o_rd_valid    (rd_valid),
      .o_rd_data     (rd_data),
      .o_rd_mode     (rd_mode),
      .o_rd_proc_val (rd_proc_val),
      .o_rd_src      (rd_src),
      .i_frame_len   (frame_len),
      .o_frame_cmplt (frame_cmplt),
      .i_flush       (flush),
      .o_count       (count),
      .o_ovf_err     (ovf_err)
   );

   always #5 clk = ~clk;

   logic [42:0] sb [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        m_ovf    = 1'b0;
   logic        exp_fc   = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one clock of stimulus, then check state against the scoreboard.
   task automatic cycle(input logic wv, input logic [31:0] d, input logic s,
                        input logic rr, input logic fl);
      logic        do_pop;
      logic        do_push;
      logic        was_full;
      logic [42:0] beat;
      beat        = {s, d[7:0] ^ 8'h5A, d[1:0], d};
      wr_valid    = wv;
      wr_data     = d;
      wr_mode     = d[1:0];
      wr_proc_val = d[7:0] ^ 8'h5A;
      wr_src      = s;
      rd_ready    = rr;
      flush       = fl;
      was_full    = (sb.size() == DEPTH);
      do_pop      = !fl && rr && (sb.size() != 0);
      do_push     = !fl && wv && !was_full;
      if (do_pop)
         check("head", 64'({rd_src, rd_proc_val, rd_mode, rd_data}), 64'(sb[0]));
      @(posedge clk);
      #1;
      if (fl) begin
         sb.delete();
         m_ovf = 1'b0;
      end else begin
         if (do_pop) void'(sb.pop_front());
         if (do_push) sb.push_back(beat);
         if (wv && was_full) m_ovf = 1'b1;
      end
      check("count", 64'(count), 64'(sb.size()));
      check("full", 64'(fifo_full), 64'(sb.size() == DEPTH));
      check("afull", 64'(fifo_afull), 64'(sb.size() >= DEPTH - 2));
      check("rd_valid", 64'(rd_valid), 64'(sb.size() != 0));
      check("ovf_err", 64'(ovf_err), 64'(m_ovf));
      check("frame_cmplt", 64'(frame_cmplt), 64'(exp_fc));
   endtask

   task automatic push(input logic [31:0] d, input logic s);
      cycle(1'b1, d, s, 1'b0, 1'b0);
   endtask

   task automatic pop();
      cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_mode = '0; wr_proc_val = '0;
      wr_src = 1'b0; rd_ready = 1'b0; frame_len = 16'd0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", 64'(count), 64'd0);
      check("rst_valid", 64'(rd_valid), 64'd0);
      check("rst_full", 64'({fifo_full, fifo_afull, ovf_err, frame_cmplt}), 64'd0);
      check("rst_data", 64'({rd_src, rd_proc_val, rd_mode, rd_data}), 64'd0);
      rst_n = 1'b1;

      // Basic FWFT ordering
      push(32'hA0, 1'b0); push(32'hA1, 1'b1); push(32'hA2, 1'b0);
      check("fwft_data", 64'(rd_data), 64'hA0);
      check("fwft_src", 64'(rd_src), 64'd0);
      repeat (3) pop();

      // Fill, overflow, drain
      for (int i = 0; i < DEPTH; i++) push(32'(i), i[0]);
      push(32'hDEAD, 1'b1);
      for (int i = 0; i < DEPTH; i++) pop();

      // Simultaneous push/pop while full, then while not full
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) push(32'(100 + i), 1'b0);
      cycle(1'b1, 32'd200, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 32'd201, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH - 1; i++) pop();

      // Streaming through pointer wrap
      push(32'd1000, 1'b0);
      for (int i = 0; i < 40; i++) cycle(1'b1, 32'(1001 + i), i[0], 1'b1, 1'b0);
      pop();

      // Frame completion with frame_len = 4
      frame_len = 16'd4;
      for (int i = 0; i < 8; i++) push(32'(300 + i), 1'b0);
      for (int i = 0; i < 8; i++) begin
         exp_fc = (i == 3) || (i == 7);
         pop();
      end
      exp_fc = 1'b0;
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

      // frame_len = 0 never pulses
      frame_len = 16'd0;
      for (int i = 0; i < 8; i++) push(32'(400 + i), 1'b1);
      for (int i = 0; i < 8; i++) pop();

      // Flush mid-frame with a concurrent write; frame restarts from beat 1
      frame_len = 16'd4;
      for (int i = 0; i < 7; i++) push(32'(500 + i), 1'b0);
      pop(); pop();
      check("pre_flush_count", 64'(count), 64'd5);
      cycle(1'b1, 32'h55, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) push(32'(600 + i), 1'b1);
      for (int i = 0; i < 4; i++) begin
         exp_fc = (i == 3);
         pop();
      end
      exp_fc = 1'b0;
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-frame abandons the frame
      for (int i = 0; i < 4; i++) push(32'(700 + i), 1'b0);
      pop(); pop();
      wr_valid = 1'b0; rd_ready = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      check("arst_count", 64'(count), 64'd0);
      check("arst_valid", 64'(rd_valid), 64'd0);
      check("arst_flags", 64'({fifo_full, fifo_afull, ovf_err, frame_cmplt}), 64'd0);
      check("arst_data", 64'({rd_src, rd_proc_val, rd_mode, rd_data}), 64'd0);
      sb.delete();
      m_ovf = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      push(32'd800, 1'b0); push(32'd801, 1'b1);
      pop(); pop();
      cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
